// File: rtl/pwm_regs.sv
// Single-channel PWM peripheral with a small register file on an adr/cs/wr/rd bus.
// Period and duty are double-buffered through shadow copies that reload only at a period wrap.
module pwm_regs #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] PERIOD_RST = '0,
  parameter logic [WIDTH-1:0] DUTY_RST   = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] adr,
  input  logic        cs,
  input  logic        wr,
  input  logic        rd,
  input  logic [31:0] d_in,
  output logic [31:0] d_out,
  output logic        pwm_out,
  output logic        period_end
);

  logic             ctrl_q, ctrl_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] sh_duty_q, sh_duty_d;
  logic [WIDTH-1:0] sh_period_q, sh_period_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]      d_out_q, d_out_d;
  logic             pwm_q, pwm_d;

  logic             aligned;
  logic             wr_en;
  logic             rd_en;
  logic             per_zero;
  logic [WIDTH-1:0] per_last;
  logic             run;
  logic             wrap;
  logic [31:0]      rdata;
  logic             adr_unused;

  assign adr_unused = ^adr[31:4];

  assign aligned = (adr[1:0] == 2'b00);
  assign wr_en   = cs & wr & aligned;
  assign rd_en   = cs & rd & ~wr & aligned;

  always_comb begin
    ctrl_d   = ctrl_q;
    duty_d   = duty_q;
    period_d = period_q;
    if (wr_en) begin
      case (adr[3:2])
        2'd0:    ctrl_d   = d_in[0];
        2'd1:    duty_d   = d_in[WIDTH-1:0];
        2'd2:    period_d = d_in[WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // A disable write stops the counter on the very edge it lands on.
  assign per_zero = (sh_period_q == '0);
  assign per_last = sh_period_q - WIDTH'(1);
  assign run      = ctrl_q & ctrl_d & ~per_zero;
  assign wrap     = run & (cnt_q == per_last);

  // Zero period while enabled counts as a permanent wrap so a new period is picked up at once.
  always_comb begin
    cnt_d       = '0;
    pwm_d       = 1'b0;
    sh_duty_d   = sh_duty_q;
    sh_period_d = sh_period_q;
    if (run) begin
      cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
      pwm_d = (cnt_q < sh_duty_q);
    end
    if (!ctrl_q || per_zero || wrap) begin
      sh_duty_d   = duty_q;
      sh_period_d = period_q;
    end
  end

  always_comb begin
    rdata = '0;
    case (adr[3:2])
      2'd0:    rdata[0]         = ctrl_q;
      2'd1:    rdata[WIDTH-1:0] = duty_q;
      2'd2:    rdata[WIDTH-1:0] = period_q;
      default: rdata[WIDTH-1:0] = cnt_q;
    endcase
    d_out_d = rd_en ? rdata : d_out_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q      <= 1'b0;
      duty_q      <= DUTY_RST;
      period_q    <= PERIOD_RST;
      sh_duty_q   <= DUTY_RST;
      sh_period_q <= PERIOD_RST;
      cnt_q       <= '0;
      d_out_q     <= '0;
      pwm_q       <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_d;
      duty_q      <= duty_d;
      period_q    <= period_d;
      sh_duty_q   <= sh_duty_d;
      sh_period_q <= sh_period_d;
      cnt_q       <= cnt_d;
      d_out_q     <= d_out_d;
      pwm_q       <= pwm_d;
    end
  end

  assign d_out      = d_out_q;
  assign pwm_out    = pwm_q;
  assign period_end = ctrl_q & ~per_zero & (cnt_q == per_last);

endmodule

// File: tb/tb_pwm_regs.sv
// Directed bench for pwm_regs: read data goes through an expected-value queue,
// waveform expectations come from the cycle count since each enable.
module tb_pwm_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adr;
  logic        cs;
  logic        wr;
  logic        rd;
  logic [31:0] d_in;
  logic [31:0] d_out;
  logic        pwm_out;
  logic        period_end;

  int          vecCount = 0;
  int          missCount = 0;
  int          j = 0;
  int          highsA;
  int          highsB;
  logic [31:0] rdq[$];

  pwm_regs dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .adr        (adr),
    .cs         (cs),
    .wr         (wr),
    .rd         (rd),
    .d_in       (d_in),
    .d_out      (d_out),
    .pwm_out    (pwm_out),
    .period_end (period_end)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    assert (obs === exp) else begin
      missCount++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h (j=%0d)", tag, obs, exp, j);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    vecCount++;
    assert (obs === exp) else begin
      missCount++;
      $error("[TB] FAIL %s: observed=%b expected=%b (j=%0d)", tag, obs, exp, j);
    end
  endtask

  task automatic applyStimulus(input logic c, input logic w, input logic r,
                               input logic [31:0] a, input logic [31:0] d);
    cs   = c;
    wr   = w;
    rd   = r;
    adr  = a;
    d_in = d;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic cyc();
    @(negedge clk);
    j++;
  endtask

  task automatic writeReg(input logic [31:0] a, input logic [31:0] d);
    applyStimulus(1'b1, 1'b1, 1'b0, a, d);
    cyc();
    idle();
  endtask

  // The expected read value is queued with the strobe and popped once d_out is due.
  task automatic readReg(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] e;
    applyStimulus(1'b1, 1'b0, 1'b1, a, 32'h0);
    rdq.push_back(exp);
    cyc();
    idle();
    e = rdq.pop_front();
    checkOutput(tag, d_out, e);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    checkBit("rst_pwm", pwm_out, 1'b0);
    checkOutput("rst_dout", d_out, 32'h0);
    rst_n = 1'b1;

    $display("[TB] reset readback");
    readReg("rd_ctrl_rst", 32'h0, 32'h0);
    readReg("rd_duty_rst", 32'h4, 32'h0);
    readReg("rd_period_rst", 32'h8, 32'h0);
    readReg("rd_count_rst", 32'hC, 32'h0);
    checkBit("pwm_idle", pwm_out, 1'b0);
    checkBit("pend_idle", period_end, 1'b0);

    $display("[TB] period 10 duty 3");
    writeReg(32'h8, 32'd10);
    writeReg(32'h4, 32'd3);
    writeReg(32'h0, 32'd1);
    j = 0;
    checkBit("pwm_start", pwm_out, 1'b0);
    checkBit("pend_start", period_end, 1'b0);
    for (int i = 0; i < 20; i++) begin
      readReg("count_run", 32'hC, 32'(i % 10));
      checkBit("pwm_run", pwm_out, (i % 10) < 3);
      checkBit("pend_run", period_end, ((i + 1) % 10) == 9);
    end

    $display("[TB] duty change mid-period");
    highsA = 0;
    highsB = 0;
    while (j < 41) begin
      if (j <= 30) checkBit("pwm_old_duty", pwm_out, ((j - 1) % 10) < 3);
      else         checkBit("pwm_new_duty", pwm_out, ((j - 1) % 10) < 7);
      if (j >= 21 && j <= 30 && pwm_out) highsA++;
      if (j >= 31 && j <= 40 && pwm_out) highsB++;
      if (j == 22) writeReg(32'h4, 32'd7);
      else         cyc();
    end
    checkOutput("highs_current", 32'(highsA), 32'd3);
    checkOutput("highs_next", 32'(highsB), 32'd7);

    $display("[TB] duty boundaries");
    writeReg(32'h4, 32'd0);
    while (j < 61) begin
      cyc();
      if (j >= 51) checkBit("pwm_duty0", pwm_out, 1'b0);
    end
    writeReg(32'h4, 32'd10);
    while (j < 81) begin
      cyc();
      if (j >= 71) checkBit("pwm_duty_full", pwm_out, 1'b1);
    end

    $display("[TB] zero period");
    writeReg(32'h8, 32'd0);
    while (j < 95) begin
      cyc();
      if (j >= 91) begin
        checkBit("pwm_per0", pwm_out, 1'b0);
        checkBit("pend_per0", period_end, 1'b0);
      end
    end
    for (int i = 0; i < 3; i++) begin
      readReg("count_per0", 32'hC, 32'h0);
      checkBit("pend_per0_rd", period_end, 1'b0);
    end
    writeReg(32'h4, 32'd2);
    writeReg(32'h8, 32'd4);
    cyc();
    checkBit("pwm_p4_start", pwm_out, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      readReg("count_p4", 32'hC, 32'((k - 1) % 4));
      checkBit("pwm_p4", pwm_out, ((k - 1) % 4) < 2);
      checkBit("pend_p4", period_end, (k % 4) == 3);
    end

    $display("[TB] bus corner cases");
    readReg("rd_period4", 32'h8, 32'd4);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h4, 32'd5);
    cyc();
    idle();
    checkOutput("wrrd_dout_hold", d_out, 32'd4);
    readReg("rd_duty_wrrd", 32'h4, 32'd5);
    writeReg(32'h0, 32'd0);
    cyc();
    checkBit("pwm_disabled", pwm_out, 1'b0);
    checkBit("pend_disabled", period_end, 1'b0);
    readReg("count_disabled", 32'hC, 32'h0);
    writeReg(32'hC, 32'h55);
    readReg("count_wr_ignored", 32'hC, 32'h0);
    writeReg(32'h6, 32'h77);
    readReg("duty_unaligned", 32'h4, 32'd5);
    writeReg(32'h2, 32'h1);
    readReg("ctrl_unaligned", 32'h0, 32'h0);
    checkBit("pwm_unaligned", pwm_out, 1'b0);

    $display("[TB] async reset mid-period");
    writeReg(32'h8, 32'd10);
    writeReg(32'h4, 32'd7);
    readReg("rd_duty7", 32'h4, 32'd7);
    writeReg(32'h0, 32'd1);
    readReg("rd_ctrl_on", 32'h0, 32'd1);
    repeat (4) cyc();
    checkBit("pwm_pre_rst", pwm_out, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkBit("pwm_async_rst", pwm_out, 1'b0);
    checkBit("pend_async_rst", period_end, 1'b0);
    checkOutput("dout_async_rst", d_out, 32'h0);
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      checkBit("pwm_post_rst", pwm_out, 1'b0);
      checkBit("pend_post_rst", period_end, 1'b0);
    end
    readReg("ctrl_post_rst", 32'h0, 32'h0);
    readReg("count_post_rst", 32'hC, 32'h0);
    readReg("period_post_rst", 32'h8, 32'h0);
    readReg("duty_post_rst", 32'h4, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
